serial_to_parallel_flex: RTL and testbench
==========================================

Name: serial_to_parallel_flex

Overview:
Parametrised deserialiser that packs narrow input beats (1 or more bits each) into a wide parallel word. It has valid/ready handshakes on both sides, selectable bit order, and early flush of a partial word via in_last. It sits after serial receive front-ends, e.g. UART/SPI bit samplers, and feeds word-wide consumers that can stall.

Parameters:
in_width, 1, bits per input beat; must be >= 1.
out_width, 8, bits per output word; must be an integer multiple of in_width (elaboration error otherwise).
msb_first, 0, 0 = first beat lands in the least significant position; 1 = first beat lands in the most significant position.
timeout, 16, idle-cycle limit for auto-flush; used only when the optional feature is compiled in; must be >= 1.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  input beat valid.
in_ready  output  1  block can accept a beat.
in_data  input  in_width  input beat.
in_last  input  1  qualified by in_valid; this beat ends the word (flush partial).
out_valid  output  1  parallel word valid.
out_ready  input  1  consumer accepts the word.
out_data  output  out_width  packed word.
out_beats  output  $clog2(beats+1)  number of valid beats in out_data, 1..beats (beats = out_width/in_width).

Behaviour:
- Reset: one clk edge with rst=1 sets out_valid=0, out_data=0, out_beats=0, beat counter=0, accumulator=0. Reset mid-word discards the partial data and emits nothing.
- Accepted beat: in_valid && in_ready at a clk edge.
- in_ready = !out_valid || out_ready. Combinational from registered state and out_ready only; it never depends on in_valid.
- Packing with msb_first=0: beat k (k = 0..beats-1 within the word) goes to bits [k*in_width +: in_width].
- Packing with msb_first=1: beat k goes to bits [out_width-1-k*in_width -: in_width].
- A word completes on an accepted beat when the beat counter == beats-1, or when in_last=1.
- On completion, at that same edge: out_data <= accumulator merged with the current beat; out_beats <= counter+1; out_valid <= 1; counter <= 0; accumulator <= 0.
- Latency: out_valid rises 1 cycle after the completing beat is accepted.
- Throughput: 1 beat/cycle sustained while out_ready=1. A back-to-back completing beat is accepted in the same cycle the previous word drains.
- Partial word: unfilled beat slots read as 0, i.e. the upper bits for msb_first=0 and the lower bits for msb_first=1.
- in_last on the beat that also fills the word: treated as a normal full word, out_beats = beats.
- in_last with in_valid=0: ignored.
- beats == 1: every accepted beat is a word; out_beats is always 1.
- Output hold: while out_valid && !out_ready, out_data and out_beats stay stable and no beat is accepted. out_valid drops on the edge where out_ready=1 unless a new word completes at that same edge.
- Counter: no wrap beyond beats-1; it returns to 0 only on completion or reset.

Optional Feature:
Macro STP_TIMEOUT_EN.
- Defined:
  - An idle counter increments each cycle the accumulator holds >= 1 beat and no beat is accepted. It clears on any accepted beat or completion.
  - When it reaches timeout and in_ready=1, the partial word is flushed exactly as if in_last had arrived, with out_beats = beats held.
  - If in_ready=0 at that point, the flush waits until in_ready=1.
  - An empty accumulator never flushes.
- Not defined: no idle counter; a partial word is emitted only via in_last; the timeout parameter is unused.

Test Plan:
- in_width=1, out_width=8, msb_first=0, out_ready=1: bits 1,0,1,1,0,0,1,0 on consecutive cycles -> out_data=8'h4D, out_beats=8, out_valid high for exactly 1 cycle, 1 cycle after the 8th beat.
- in_width=2, out_width=8, msb_first=1: beats 2'b11,2'b00,2'b10,2'b01 -> out_data=8'hC9, out_beats=4. With msb_first=0 the same beats -> out_data=8'h63.
- in_width=2, out_width=8, msb_first=0:
  - beats 2'b01, 2'b10 with in_last on the 2nd -> out_data=8'h09, out_beats=2.
  - Next 4 beats form an independent full word.
- Backpressure: out_ready=0 for 5 cycles after a word completes -> in_ready=0, out_data stable. Then out_ready=1 -> word drains, in_ready=1 the same cycle, no beat is lost or duplicated across a 3-word random stream.
- Assert rst after 3 of 8 beats -> no out_valid. The next 8 beats produce exactly one correct word.
- With STP_TIMEOUT_EN and timeout=4: send 3 bits 1,1,0 then idle -> out_data=8'h03, out_beats=3 after 4 idle cycles. Without the macro, no output appears.

Source files
------------

// File: rtl/serial_to_parallel_flex.sv
// serial_to_parallel_flex
// Deserialiser that packs in_width-bit input beats into an out_width-bit word.
// Both sides use valid/ready handshakes. The bit order is selectable with msb_first.
// A partial word can be flushed early by asserting in_last on a beat.
// Optional feature: define STP_TIMEOUT_EN to flush a partial word automatically
// after `timeout` consecutive idle cycles.

module serial_to_parallel_flex #(
    parameter int in_width  = 1,
    parameter int out_width = 8,
    parameter bit msb_first = 1'b0,
    parameter int timeout   = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        in_valid,
    output logic                                        in_ready,
    input  logic [in_width-1:0]                         in_data,
    input  logic                                        in_last,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic [out_width-1:0]                        out_data,
    output logic [$clog2(out_width/in_width+1)-1:0]     out_beats
);

    localparam int BEATS = out_width / in_width;
    localparam int BW    = $clog2(BEATS + 1);

    generate
        if (in_width < 1 || (out_width % in_width) != 0) begin : g_bad_width
            $error("serial_to_parallel_flex: out_width must be a positive multiple of in_width");
        end
    endgenerate

    logic [BW-1:0]        r_count;
    logic [out_width-1:0] r_acc;
    logic                 r_out_valid;
    logic [out_width-1:0] r_out_data;
    logic [BW-1:0]        r_out_beats;

    logic                 w_accept;
    logic                 w_complete;
    logic                 w_flush;
    logic                 w_emit;
    logic [BW-1:0]        w_count_inc;
    logic [out_width-1:0] w_beat_placed;
    logic [out_width-1:0] w_merged;
    logic [out_width-1:0] w_emit_data;
    logic [BW-1:0]        w_emit_beats;

    // The input side is free whenever the output register is empty or draining this cycle.
    assign in_ready    = !r_out_valid || out_ready;
    assign w_accept    = in_valid && in_ready;
    assign w_count_inc = r_count + 1'b1;
    assign w_complete  = w_accept && ((r_count == BW'(BEATS - 1)) || in_last);

    // Place the incoming beat in the slot selected by the beat counter.
    always_comb begin
        // NOTE: default first so every path assigns the signal and no latch is inferred.
        w_beat_placed = '0;
        if (msb_first) begin
            w_beat_placed = out_width'(in_data) << (out_width - in_width - int'(r_count) * in_width);
        end else begin
            w_beat_placed = out_width'(in_data) << (int'(r_count) * in_width);
        end
    end

    assign w_merged = r_acc | w_beat_placed;

`ifdef STP_TIMEOUT_EN
    localparam int IDLE_W = $clog2(timeout + 1);

    generate
        if (timeout < 1) begin : g_bad_timeout
            $error("serial_to_parallel_flex: timeout must be >= 1");
        end
    endgenerate

    logic [IDLE_W-1:0] r_idle;

    // Flush a waiting partial word once it has sat idle for `timeout` cycles
    // and the output register can take it.
    assign w_flush = (r_count != '0) && !w_accept && in_ready && (r_idle == IDLE_W'(timeout));

    // Count idle cycles while a partial word is held; saturate at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle <= '0;
        end else if (w_accept || w_flush || r_count == '0) begin
            r_idle <= '0;
        end else if (r_idle != IDLE_W'(timeout)) begin
            r_idle <= r_idle + 1'b1;
        end
    end
`else
    assign w_flush = 1'b0;
`endif

    // A completing beat merges into the word. A flush emits the accumulator as it stands.
    assign w_emit       = w_complete || w_flush;
    assign w_emit_data  = w_complete ? w_merged    : r_acc;
    assign w_emit_beats = w_complete ? w_count_inc : r_count;

    // Accumulate beats and move each finished word into the output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_beats <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_emit_data;
                r_out_beats <= w_emit_beats;
                r_count     <= '0;
                r_acc       <= '0;
            end else begin
                if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
                if (w_accept) begin
                    r_acc   <= w_merged;
                    r_count <= w_count_inc;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_beats = r_out_beats;

endmodule

// File: tb/tb_serial_to_parallel_flex.sv
// tb_serial_to_parallel_flex
// There are three instances of serial_to_parallel_flex:
//   dut 0: in_width=1, msb_first=0, timeout=4
//   dut 1: in_width=2, msb_first=1
//   dut 2: in_width=2, msb_first=0
// All three use out_width=8.
// A queue-of-beats reference model rebuilds each expected word from the beat list,
// using plain shift arithmetic. Timeout expectations follow STP_TIMEOUT_EN.

module tb_serial_to_parallel_flex;

    logic clk;
    logic rst;

    logic       in_valid_v  [3];
    logic       in_last_v   [3];
    logic       out_ready_v [3];
    logic [1:0] in_data_v   [3];

    wire        in_ready_w  [3];
    wire        out_valid_w [3];
    wire  [7:0] out_data_w  [3];
    wire  [3:0] beats_a;
    wire  [2:0] beats_b;
    wire  [2:0] beats_c;

    serial_to_parallel_flex #(.in_width(1), .out_width(8), .msb_first(1'b0), .timeout(4)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]), .in_data(in_data_v[0][0:0]),
        .in_last(in_last_v[0]), .out_valid(out_valid_w[0]), .out_ready(out_ready_v[0]),
        .out_data(out_data_w[0]), .out_beats(beats_a)
    );

    serial_to_parallel_flex #(.in_width(2), .out_width(8), .msb_first(1'b1), .timeout(16)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]), .in_data(in_data_v[1]),
        .in_last(in_last_v[1]), .out_valid(out_valid_w[1]), .out_ready(out_ready_v[1]),
        .out_data(out_data_w[1]), .out_beats(beats_b)
    );

    serial_to_parallel_flex #(.in_width(2), .out_width(8), .msb_first(1'b0), .timeout(16)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]), .in_data(in_data_v[2]),
        .in_last(in_last_v[2]), .out_valid(out_valid_w[2]), .out_ready(out_ready_v[2]),
        .out_data(out_data_w[2]), .out_beats(beats_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bound the whole run so a stuck design cannot hang the simulation.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time reached 2000000, limit for completion 2000000");
        $fatal(1);
    end

    int errors;
    int checks;

    // Per-instance configuration used by the reference model.
    int iw_cfg  [3] = '{1, 2, 2};
    int msb_cfg [3] = '{0, 1, 0};

    // Reference model state: beats of the word in progress and expected words.
    int beat_buf   [3][8];
    int cnt        [3];
    int exp_data   [3][32];
    int exp_beats  [3][32];
    int exp_head   [3];
    int exp_tail   [3];
    int words_done [3];

    bit done_now     [3];
    bit accepted     [3];
    bit smp_in_ready [3];
    bit skip_sb      [3];
    bit sampled_rst;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expd);
        end
    endtask

    function automatic int beats_of(input int d);
        case (d)
            0:       return int'(beats_a);
            1:       return int'(beats_b);
            default: return int'(beats_c);
        endcase
    endfunction

    // Record an accepted beat and close the word on a full count or on in_last.
    function automatic void model_push(input int d, input logic [1:0] data, input logic last);
        int word;
        int shift;
        beat_buf[d][cnt[d]] = int'(data) & ((1 << iw_cfg[d]) - 1);
        cnt[d] = cnt[d] + 1;
        if (cnt[d] == 8 / iw_cfg[d] || last) begin
            word = 0;
            for (int k = 0; k < cnt[d]; k++) begin
                shift = (msb_cfg[d] != 0) ? 8 - (k + 1) * iw_cfg[d] : k * iw_cfg[d];
                word  = word | (beat_buf[d][k] << shift);
            end
            exp_data[d][exp_tail[d] % 32]  = word & 8'hFF;
            exp_beats[d][exp_tail[d] % 32] = cnt[d];
            exp_tail[d]   = exp_tail[d] + 1;
            cnt[d]        = 0;
            words_done[d] = words_done[d] + 1;
            done_now[d]   = 1'b1;
        end
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            cnt[d]      = 0;
            exp_head[d] = exp_tail[d];
            done_now[d] = 1'b0;
        end
    endfunction

    // One clock cycle.
    // Entered and left 1 time unit after a rising edge, with the inputs already driven.
    // The DUTs are sampled mid-cycle.
    task automatic step();
        #1;
        for (int d = 0; d < 3; d++) begin
            smp_in_ready[d] = in_ready_w[d];
            accepted[d]     = !rst && in_valid_v[d] && in_ready_w[d];
            done_now[d]     = 1'b0;
            if (!rst && out_valid_w[d] && out_ready_v[d] && !skip_sb[d]) begin
                check($sformatf("dut%0d_spurious_word", d), 32'(exp_tail[d] != exp_head[d]), 32'd1);
                if (exp_tail[d] != exp_head[d]) begin
                    check($sformatf("dut%0d_word_data", d), 32'(out_data_w[d]),
                          32'(exp_data[d][exp_head[d] % 32]));
                    check($sformatf("dut%0d_word_beats", d), 32'(beats_of(d)),
                          32'(exp_beats[d][exp_head[d] % 32]));
                    exp_head[d] = exp_head[d] + 1;
                end
            end
            if (accepted[d]) model_push(d, in_data_v[d], in_last_v[d]);
        end
        sampled_rst = rst;
        @(posedge clk);
        #1;
        if (sampled_rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (done_now[d]) check($sformatf("dut%0d_latency", d), 32'(out_valid_w[d]), 32'd1);
            end
        end
    endtask

    // Offer one beat until it is accepted; optionally randomise out_ready meanwhile.
    task automatic send_beat(input int d, input logic [1:0] data, input logic last, input bit rand_or);
        int tries;
        tries = 0;
        in_valid_v[d] = 1'b1;
        in_data_v[d]  = data;
        in_last_v[d]  = last;
        do begin
            if (rand_or) out_ready_v[d] = 1'($urandom_range(0, 1));
            step();
            tries++;
        end while (!accepted[d] && tries < 60);
        check($sformatf("dut%0d_beat_accepted", d), 32'(accepted[d]), 32'd1);
        in_valid_v[d] = 1'b0;
        in_last_v[d]  = 1'b0;
    endtask

    // Random beats with short gaps, random in_last and random out_ready.
    // Runs until nwords more words have completed.
    task automatic run_stream(input int d, input int nwords);
        int target;
        target = words_done[d] + nwords;
        while (words_done[d] < target) begin
            repeat ($urandom_range(0, 1)) begin
                out_ready_v[d] = 1'($urandom_range(0, 1));
                step();
            end
            send_beat(d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 5) == 0), 1'b1);
        end
    endtask

    task automatic drain(input int n);
        for (int d = 0; d < 3; d++) out_ready_v[d] = 1'b1;
        repeat (n) step();
    endtask

    logic [7:0] bits;
    logic [7:0] pat;
    logic [7:0] hold_word;
    logic [7:0] tmo_data;
    int         tmo_beats;
    int         seen;

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid_v[d]  = 1'b0;
            in_last_v[d]   = 1'b0;
            in_data_v[d]   = 2'b00;
            out_ready_v[d] = 1'b1;
            cnt[d]         = 0;
            exp_head[d]    = 0;
            exp_tail[d]    = 0;
            words_done[d]  = 0;
            skip_sb[d]     = 1'b0;
        end

        // Reset values.
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("dut%0d_rst_out_valid", d), 32'(out_valid_w[d]), 32'd0);
            check($sformatf("dut%0d_rst_out_data", d), 32'(out_data_w[d]), 32'd0);
            check($sformatf("dut%0d_rst_out_beats", d), 32'(beats_of(d)), 32'd0);
            check($sformatf("dut%0d_rst_in_ready", d), 32'(in_ready_w[d]), 32'd1);
        end

        // Serial bits 1,0,1,1,0,0,1,0 LSB first give 0x4D; out_valid pulses for one cycle.
        bits = 8'h4D;
        for (int i = 0; i < 8; i++) send_beat(0, {1'b0, bits[i]}, 1'b0, 1'b0);
        check("bits_out_valid", 32'(out_valid_w[0]), 32'd1);
        check("bits_out_data", 32'(out_data_w[0]), 32'h4D);
        check("bits_out_beats", 32'(beats_a), 32'd8);
        step();
        check("bits_valid_one_cycle", 32'(out_valid_w[0]), 32'd0);

        // Beats 11,00,10,01: MSB first gives 0xC9, LSB first gives 0x63.
        pat = 8'b11_00_10_01;
        for (int k = 0; k < 4; k++) send_beat(1, pat[7-2*k -: 2], 1'b0, 1'b0);
        check("msb_first_data", 32'(out_data_w[1]), 32'hC9);
        check("msb_first_beats", 32'(beats_b), 32'd4);
        for (int k = 0; k < 4; k++) send_beat(2, pat[7-2*k -: 2], 1'b0, 1'b0);
        check("lsb_first_data", 32'(out_data_w[2]), 32'h63);
        check("lsb_first_beats", 32'(beats_c), 32'd4);
        step();

        // Early flush with in_last, then a full word with in_last on the filling beat.
        send_beat(2, 2'b01, 1'b0, 1'b0);
        send_beat(2, 2'b10, 1'b1, 1'b0);
        check("partial_data", 32'(out_data_w[2]), 32'h09);
        check("partial_beats", 32'(beats_c), 32'd2);
        send_beat(2, 2'b10, 1'b0, 1'b0);
        send_beat(2, 2'b11, 1'b0, 1'b0);
        send_beat(2, 2'b00, 1'b0, 1'b0);
        send_beat(2, 2'b01, 1'b1, 1'b0);
        check("last_on_full_data", 32'(out_data_w[2]), 32'h4E);
        check("last_on_full_beats", 32'(beats_c), 32'd4);
        step();

        // Backpressure: hold the word for 5 cycles, then drain while a new beat enters.
        for (int k = 0; k < 4; k++) send_beat(2, 2'($urandom_range(0, 3)), 1'b0, 1'b0);
        hold_word          = 8'(exp_data[2][exp_head[2] % 32]);
        out_ready_v[2]     = 1'b0;
        in_valid_v[2]      = 1'b1;
        in_data_v[2]       = 2'($urandom_range(0, 3));
        in_last_v[2]       = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_in_ready_low", 32'(smp_in_ready[2]), 32'd0);
            check("bp_out_valid_held", 32'(out_valid_w[2]), 32'd1);
            check("bp_out_data_stable", 32'(out_data_w[2]), 32'(hold_word));
        end
        out_ready_v[2] = 1'b1;
        step();
        check("bp_in_ready_on_drain", 32'(smp_in_ready[2]), 32'd1);
        check("bp_beat_taken_on_drain", 32'(accepted[2]), 32'd1);
        in_valid_v[2] = 1'b0;
        run_stream(2, 3);
        run_stream(1, 3);
        drain(3);
        check("stream_c_all_words", 32'(exp_tail[2] - exp_head[2]), 32'd0);
        check("stream_b_all_words", 32'(exp_tail[1] - exp_head[1]), 32'd0);

        // Reset after 3 of 8 beats discards the partial word.
        for (int i = 0; i < 3; i++) send_beat(0, 2'($urandom_range(0, 1)), 1'b0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid_w[0]), 32'd0);
        step();
        check("midrst_no_word", 32'(out_valid_w[0]), 32'd0);
        for (int i = 0; i < 8; i++) send_beat(0, 2'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("midrst_word_valid", 32'(out_valid_w[0]), 32'd1);
        drain(2);
        check("midrst_all_words", 32'(exp_tail[0] - exp_head[0]), 32'd0);

        // Idle partial word: bits 1,1,0 then silence.
        skip_sb[0] = 1'b1;
        send_beat(0, 2'b01, 1'b0, 1'b0);
        send_beat(0, 2'b01, 1'b0, 1'b0);
        send_beat(0, 2'b00, 1'b0, 1'b0);
        seen      = -1;
        tmo_data  = 8'h00;
        tmo_beats = 0;
        for (int i = 1; i <= 12 && seen < 0; i++) begin
            step();
            if (out_valid_w[0]) begin
                seen      = i;
                tmo_data  = out_data_w[0];
                tmo_beats = int'(beats_a);
            end
        end
`ifdef STP_TIMEOUT_EN
        check("tmo_flushed", 32'(seen > 0), 32'd1);
        check("tmo_not_before_limit", 32'(seen >= 4), 32'd1);
        check("tmo_data", 32'(tmo_data), 32'h03);
        check("tmo_beats", 32'(tmo_beats), 32'd3);
`else
        check("no_tmo_output", 32'(seen < 0), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
